connect4_win_checker: RTL

- Reads the 42-cell gameboard and player-cell vectors produced by the column-selector writer.
- After each token drop, it sequentially scans every four-in-a-row line and reports the outcome to the game FSM: a P1 win, a P2 win, a full board (draw), or continue.
- Sits between the column selector and the turn/END_GAME state machine.

---
 rtl/connect4_pkg.sv | 35 +++
 rtl/connect4_win_checker_line_check.sv | 87 ++++++++
 rtl/connect4_win_checker.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 constants: board geometry, players, line step sizes,
// game FSM states and the win-checker FSM encoding.
package connect4_pkg;

   localparam int ROWS    = 6;
   localparam int COLS    = 7;
   localparam int WIN_LEN = 4;
   localparam int CELLS   = ROWS * COLS;

   localparam logic [CELLS-1:0] CELL_ONE  = 42'd1;
   localparam logic [7:0]       LAST_PAIR = 8'd167;

   localparam logic PLAYER1 = 1'b0;
   localparam logic PLAYER2 = 1'b1;

   // Index distance between consecutive cells of a line, per direction
   localparam logic [6:0] STEP_H = 7'd1;
   localparam logic [6:0] STEP_V = 7'd7;
   localparam logic [6:0] STEP_D = 7'd8;
   localparam logic [6:0] STEP_A = 7'd6;

   typedef enum logic [1:0] {
      GAME_INIT = 2'd0,
      P1_TURN   = 2'd1,
      P2_TURN   = 2'd2,
      END_GAME  = 2'd3
   } game_state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } chk_state_t;

endpackage

// File: rtl/connect4_win_checker_line_check.sv
// Combinational test of one (anchor, direction) line of four cells.
// The cell mask output exists only when CONNECT4_WIN_MASK_EN is defined.
module line_check
   import connect4_pkg::*;
(
`ifdef CONNECT4_WIN_MASK_EN
   output logic [CELLS-1:0] mask,
`endif
   input  logic [5:0]       anchor,
   input  logic [1:0]       dir,
   input  logic [CELLS-1:0] gameboard,
   input  logic [CELLS-1:0] players_cells,
   output logic             valid,
   output logic             hit,
   output logic             owner
);

   logic [5:0]         row_s;
   logic [5:0]         col_s;
   logic [6:0]         step_s;
   logic [6:0]         idx_s [WIN_LEN];
   logic [WIN_LEN-1:0] occ_s;
   logic [WIN_LEN-1:0] own_s;

   // Out-of-range indices (invalid pairs) read as 0
   function automatic logic cell_bit(input logic [CELLS-1:0] vec, input logic [6:0] idx);
      logic [CELLS-1:0] shifted;
      shifted = vec >> idx;
      return shifted[0];
   endfunction

   // Decode anchor position and pick the step and fit condition for dir
   always_comb begin
      row_s  = anchor / 6'd7;
      col_s  = anchor % 6'd7;
      valid  = 1'b0;
      step_s = 7'd0;
      case (dir)
         2'd0: begin
            valid  = (col_s <= 6'd3);
            step_s = STEP_H;
         end
         2'd1: begin
            valid  = (row_s <= 6'd2);
            step_s = STEP_V;
         end
         2'd2: begin
            valid  = (col_s <= 6'd3) && (row_s <= 6'd2);
            step_s = STEP_D;
         end
         2'd3: begin
            valid  = (col_s >= 6'd3) && (row_s <= 6'd2);
            step_s = STEP_A;
         end
         default: begin
            valid  = 1'b0;
            step_s = 7'd0;
         end
      endcase
   end

   // Gather the four cells and require full occupancy by a single owner
   always_comb begin
      for (int i = 0; i < WIN_LEN; i++) begin
         idx_s[i] = {1'b0, anchor} + 7'(i) * step_s;
         occ_s[i] = cell_bit(gameboard, idx_s[i]);
         own_s[i] = cell_bit(players_cells, idx_s[i]);
      end
      owner = own_s[0];
      hit   = valid && (&occ_s) && ((&own_s) || (own_s == {WIN_LEN{1'b0}}));
   end

`ifdef CONNECT4_WIN_MASK_EN
   // One-hot bits of the line cells; empty for a pair that does not fit
   always_comb begin
      mask = {CELLS{1'b0}};
      if (valid) begin
         for (int i = 0; i < WIN_LEN; i++) begin
            mask = mask | (CELL_ONE << idx_s[i]);
         end
      end else begin
         mask = {CELLS{1'b0}};
      end
   end
`endif

endmodule

// File: rtl/connect4_win_checker.sv
// Sequential four-in-a-row scanner: one (anchor, dir) pair per cycle over a
// snapshot of the board. Define CONNECT4_WIN_MASK_EN to report winning cells.
module connect4_win_checker
   import connect4_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CELLS-1:0] in_gameboard,
   input  logic [CELLS-1:0] in_players_cells,
   output logic             busy,
   output logic             done,
   output logic             winner_valid,
   output logic             winner,
   output logic             board_full,
   output logic [CELLS-1:0] win_cells
);

   chk_state_t       state_r;
   chk_state_t       next_state_s;
   logic [7:0]       pair_r;
   logic [CELLS-1:0] board_r;
   logic [CELLS-1:0] owners_r;
   logic             busy_r;
   logic             done_r;
   logic             winner_valid_r;
   logic             winner_r;
   logic             board_full_r;
   logic             line_valid_s;
   logic             line_hit_s;
   logic             line_owner_s;
   logic             pair_hit_s;

`ifdef CONNECT4_WIN_MASK_EN
   logic [CELLS-1:0] line_mask_s;
   logic [CELLS-1:0] mask_r;
`endif

   line_check u_line_check (
`ifdef CONNECT4_WIN_MASK_EN
      .mask          (line_mask_s),
`endif
      .anchor        (pair_r[7:2]),
      .dir           (pair_r[1:0]),
      .gameboard     (board_r),
      .players_cells (owners_r),
      .valid         (line_valid_s),
      .hit           (line_hit_s),
      .owner         (line_owner_s)
   );

   assign pair_hit_s = line_valid_s & line_hit_s;

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = SCAN;
            end else begin
               next_state_s = IDLE;
            end
         end
         SCAN: begin
            if (pair_hit_s || (pair_r == LAST_PAIR)) begin
               next_state_s = DONE;
            end else begin
               next_state_s = SCAN;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State, pair counter, snapshot and registered results
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= IDLE;
         pair_r         <= 8'd0;
         board_r        <= {CELLS{1'b0}};
         owners_r       <= {CELLS{1'b0}};
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         winner_valid_r <= 1'b0;
         winner_r       <= 1'b0;
         board_full_r   <= 1'b0;
`ifdef CONNECT4_WIN_MASK_EN
         mask_r         <= {CELLS{1'b0}};
`endif
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s == SCAN);
         // done trails the DONE state by one cycle
         done_r  <= (state_r == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  board_r        <= in_gameboard;
                  owners_r       <= in_players_cells;
                  pair_r         <= 8'd0;
                  winner_valid_r <= 1'b0;
                  winner_r       <= 1'b0;
                  board_full_r   <= 1'b0;
`ifdef CONNECT4_WIN_MASK_EN
                  mask_r         <= {CELLS{1'b0}};
`endif
               end
            end
            SCAN: begin
               if (pair_hit_s) begin
                  winner_valid_r <= 1'b1;
                  winner_r       <= line_owner_s;
`ifdef CONNECT4_WIN_MASK_EN
                  mask_r         <= line_mask_s;
`endif
               end else if (pair_r == LAST_PAIR) begin
                  board_full_r <= &board_r;
               end else begin
                  pair_r <= pair_r + 8'd1;
               end
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

   assign busy         = busy_r;
   assign done         = done_r;
   assign winner_valid = winner_valid_r;
   assign winner       = winner_r;
   assign board_full   = board_full_r;
`ifdef CONNECT4_WIN_MASK_EN
   assign win_cells    = mask_r;
`else
   assign win_cells    = {CELLS{1'b0}};
`endif

endmodule
